// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receive sequencer with mid-bit sampling and one-clk frame-complete flag
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] raw_data,
    output logic                 start_bit,
    output logic                 parity_bit,
    output logic                 stop_bit,
    output logic                 recieved_flag,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_cnt_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic                 armed, armed_n;
    logic [1:0]           ptype, ptype_n;
    logic [DATA_BITS-1:0] raw_n;
    logic                 start_n, parity_n, stop_n, flag_n;
    logic                 sample, has_par, new_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            armed         <= 1'b1;
            ptype         <= 2'b00;
            raw_data      <= '0;
            start_bit     <= 1'b0;
            parity_bit    <= 1'b1;
            stop_bit      <= 1'b1;
            recieved_flag <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_cnt_n;
            bit_cnt       <= bit_cnt_n;
            armed         <= armed_n;
            ptype         <= ptype_n;
            raw_data      <= raw_n;
            start_bit     <= start_n;
            parity_bit    <= parity_n;
            stop_bit      <= stop_n;
            recieved_flag <= flag_n;
            rx_busy       <= state_n != IDLE;
        end
    end

    assign has_par = (ptype == 2'b01) || (ptype == 2'b10);
    assign new_par = (parity_type == 2'b01) || (parity_type == 2'b10);
    assign sample  = baud_tick && (tick_cnt == ((state == START) ? HALF : FULL));

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        armed_n    = armed;
        ptype_n    = ptype;
        raw_n      = raw_data;
        start_n    = start_bit;
        parity_n   = parity_bit;
        stop_n     = stop_bit;
        flag_n     = 1'b0;
        if (baud_tick && state inside {START, DATA, PARITY, STOP})
            tick_cnt_n = sample ? '0 : tick_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (baud_tick && rx_in)
                    armed_n = 1'b1;
                if (baud_tick && !rx_in && armed) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end
            end
            START: begin
                if (sample) begin
                    state_n   = rx_in ? IDLE : DATA;
                    start_n   = rx_in ? start_bit : 1'b0;
                    bit_cnt_n = rx_in ? bit_cnt : 4'd0;
                    ptype_n   = rx_in ? ptype : parity_type;
                    parity_n  = (!rx_in && !new_par) ? 1'b1 : parity_bit;
                end
            end
            DATA: begin
                if (sample) begin
                    raw_n     = {rx_in, raw_data[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST)
                        state_n = has_par ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample) begin
                    parity_n = rx_in;
                    state_n  = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    stop_n  = rx_in;
                    armed_n = rx_in;
                    state_n = DONE;
                end
            end
            DONE: begin
                flag_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
